// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer, countdown timer and score keeper for the shooter
`timescale 1ns/1ps
module game_round_ctrl #(
    parameter int SCORE_W       = 14,
    parameter int MAX_SCORE     = 9999,
    parameter int ROUND_TICKS   = 60,
    parameter int RESPAWN_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic [2:0]         hit,
    input  logic               robot_hit,
    output logic [2:0]         game_state,
    output logic               run_en,
    output logic [2:0]         respawn,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] h_score,
    output logic [SCORE_W-1:0] rounds,
    output logic [7:0]         time_left,
    output logic               new_high
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_RESPAWN = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(MAX_SCORE);
    localparam logic [7:0]         ROUND_T = 8'(ROUND_TICKS);
    localparam logic [7:0]         RESP_T  = 8'(RESPAWN_TICKS);

    state_e             state_q;
    logic [SCORE_W-1:0] score_q, h_score_q, rounds_q;
    logic [7:0]         time_q;
    logic               run_en_q, new_high_q;
    logic [2:0]         respawn_q;

    logic [1:0]         hit_cnt;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_d, rounds_d;
    logic [7:0]         time_d;
    logic               expire;

    // Saturating score/round increments and the tick-gated countdown value.
    always_comb begin
        hit_cnt   = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
        score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, hit_cnt};
        score_d   = (score_sum > {1'b0, MAX_S}) ? MAX_S : score_sum[SCORE_W-1:0];
        rounds_d  = (rounds_q >= MAX_S) ? MAX_S : rounds_q + SCORE_W'(1);
        expire    = tick && (time_q == 8'd1);
        time_d    = (tick && (time_q != 8'd0)) ? time_q - 8'd1 : time_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            h_score_q  <= '0;
            rounds_q   <= '0;
            time_q     <= '0;
            run_en_q   <= 1'b0;
            respawn_q  <= '0;
            new_high_q <= 1'b0;
        end else begin
            respawn_q  <= '0;
            new_high_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    run_en_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_PLAY;
                        run_en_q  <= 1'b1;
                        score_q   <= '0;
                        rounds_q  <= SCORE_W'(1);
                        time_q    <= ROUND_T;
                        respawn_q <= 3'b111;
                    end
                end
                ST_PLAY: begin
                    score_q <= score_d;
                    if (robot_hit) begin
                        // Same-cycle hits are already folded into score_d for the compare.
                        state_q  <= ST_OVER;
                        run_en_q <= 1'b0;
                        time_q   <= time_d;
                        if (score_d > h_score_q) begin
                            h_score_q  <= score_d;
                            new_high_q <= 1'b1;
                        end
                    end else if (expire) begin
                        state_q  <= ST_RESPAWN;
                        run_en_q <= 1'b0;
                        time_q   <= RESP_T;
                        rounds_q <= rounds_d;
                    end else begin
                        time_q <= time_d;
                        if (pause) begin
                            state_q  <= ST_PAUSED;
                            run_en_q <= 1'b0;
                        end else begin
                            run_en_q <= 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_q  <= ST_PLAY;
                        run_en_q <= 1'b1;
                    end else begin
                        run_en_q <= 1'b0;
                    end
                end
                ST_RESPAWN: begin
                    if (expire) begin
                        state_q   <= ST_PLAY;
                        run_en_q  <= 1'b1;
                        time_q    <= ROUND_T;
                        respawn_q <= 3'b111;
                    end else begin
                        run_en_q <= 1'b0;
                        time_q   <= time_d;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    run_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign game_state = state_q;
    assign run_en     = run_en_q;
    assign respawn    = respawn_q;
    assign score      = score_q;
    assign h_score    = h_score_q;
    assign rounds     = rounds_q;
    assign time_left  = time_q;
    assign new_high   = new_high_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed and randomized checks of game_round_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_game_round_ctrl;

    localparam int SW   = 14;
    localparam int MAXS = 9999;
    localparam int RT   = 60;
    localparam int PT   = 8;
    localparam int IDLE = 0, PLAY = 1, PAUSED = 2, RESPAWN = 3, OVER = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0, start = 1'b0, pause = 1'b0, robot_hit = 1'b0;
    logic [2:0]    hit = 3'b000;
    logic [2:0]    game_state, respawn;
    logic          run_en, new_high;
    logic [SW-1:0] score, h_score, rounds;
    logic [7:0]    time_left;

    int n_checks = 0;
    int n_fail   = 0;
    int m_state, m_score, m_hs, m_rounds, m_time, m_resp, m_nh;

    game_round_ctrl #(
        .SCORE_W(SW), .MAX_SCORE(MAXS), .ROUND_TICKS(RT), .RESPAWN_TICKS(PT)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .hit(hit), .robot_hit(robot_hit), .game_state(game_state), .run_en(run_en),
        .respawn(respawn), .score(score), .h_score(h_score), .rounds(rounds),
        .time_left(time_left), .new_high(new_high)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXS) ? MAXS : v;
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_score = 0; m_hs = 0; m_rounds = 0;
        m_time = 0; m_resp = 0; m_nh = 0;
    endtask

    task automatic model_new_game();
        m_state = PLAY; m_score = 0; m_rounds = 1; m_time = RT; m_resp = 7;
    endtask

    // Game rules expressed directly on integers, one clock at a time.
    task automatic model_step(input bit t, input bit s, input bit p, input bit [2:0] h, input bit rh);
        m_resp = 0;
        m_nh   = 0;
        case (m_state)
            IDLE, OVER: if (s) model_new_game();
            PLAY: begin
                m_score = sat(m_score + $countones(h));
                if (rh) begin
                    m_state = OVER;
                    if (t && m_time > 0) m_time--;
                    if (m_score > m_hs) begin m_hs = m_score; m_nh = 1; end
                end else if (t && m_time == 1) begin
                    m_state  = RESPAWN;
                    m_time   = PT;
                    m_rounds = sat(m_rounds + 1);
                end else begin
                    if (t && m_time > 0) m_time--;
                    if (p) m_state = PAUSED;
                end
            end
            PAUSED: if (!p) m_state = PLAY;
            RESPAWN: if (t) begin
                if (m_time == 1) begin m_state = PLAY; m_time = RT; m_resp = 7; end
                else m_time--;
            end
            default: m_state = IDLE;
        endcase
    endtask

    task automatic check_model();
        check_eq("model.state",    int'(game_state), m_state);
        check_eq("model.run_en",   int'(run_en),     int'(m_state == PLAY));
        check_eq("model.respawn",  int'(respawn),    m_resp);
        check_eq("model.score",    int'(score),      m_score);
        check_eq("model.h_score",  int'(h_score),    m_hs);
        check_eq("model.rounds",   int'(rounds),     m_rounds);
        check_eq("model.time",     int'(time_left),  m_time);
        check_eq("model.new_high", int'(new_high),   m_nh);
    endtask

    // Called just after a falling edge; drives inputs, clocks once, checks at the next falling edge.
    task automatic step(input bit t, input bit s, input bit p, input bit [2:0] h, input bit rh);
        tick = t; start = s; pause = p; hit = h; robot_hit = rh;
        @(posedge clk);
        model_step(t, s, p, h, rh);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".state"},    int'(game_state), 0);
        check_eq({tag, ".run_en"},   int'(run_en),     0);
        check_eq({tag, ".respawn"},  int'(respawn),    0);
        check_eq({tag, ".score"},    int'(score),      0);
        check_eq({tag, ".h_score"},  int'(h_score),    0);
        check_eq({tag, ".rounds"},   int'(rounds),     0);
        check_eq({tag, ".time"},     int'(time_left),  0);
        check_eq({tag, ".new_high"}, int'(new_high),   0);
    endtask

    initial begin
        bit p_lvl;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Start from IDLE
        step(0, 1, 0, 3'b000, 0);
        check_eq("start.state", int'(game_state), PLAY);
        check_eq("start.rounds", int'(rounds), 1);
        check_eq("start.time", int'(time_left), RT);
        check_eq("start.respawn", int'(respawn), 7);
        check_eq("start.run_en", int'(run_en), 1);
        step(0, 0, 0, 3'b000, 0);
        check_eq("start.respawn_1cyc", int'(respawn), 0);

        // Hit accumulation
        step(0, 0, 0, 3'b101, 0);
        step(0, 0, 0, 3'b111, 0);
        check_eq("hits.score", int'(score), 5);

        // Round expiry and respawn
        repeat (59) step(1, 0, 0, 3'b000, 0);
        check_eq("expiry.time_before", int'(time_left), 1);
        step(1, 0, 0, 3'b000, 0);
        check_eq("expiry.state", int'(game_state), RESPAWN);
        check_eq("expiry.rounds", int'(rounds), 2);
        check_eq("expiry.run_en", int'(run_en), 0);
        repeat (8) step(1, 1, 1, 3'b000, 0);
        check_eq("respawn.state", int'(game_state), PLAY);
        check_eq("respawn.time", int'(time_left), RT);
        check_eq("respawn.pulse", int'(respawn), 7);

        // Pause freezes the round
        repeat (30) step(1, 0, 0, 3'b000, 0);
        step(0, 0, 1, 3'b000, 0);
        repeat (10) step(1, 0, 1, 3'b111, 1);
        check_eq("pause.state", int'(game_state), PAUSED);
        check_eq("pause.time", int'(time_left), 30);
        check_eq("pause.score", int'(score), 5);
        step(0, 0, 0, 3'b000, 0);
        step(1, 0, 0, 3'b000, 0);
        check_eq("resume.time", int'(time_left), 29);

        // High score update, then a tie that must not update
        step(0, 0, 0, 3'b011, 0);
        check_eq("hs.score7", int'(score), 7);
        step(0, 0, 0, 3'b001, 1);
        check_eq("hs.state", int'(game_state), OVER);
        check_eq("hs.h_score", int'(h_score), 8);
        check_eq("hs.new_high", int'(new_high), 1);
        step(0, 0, 0, 3'b000, 0);
        check_eq("hs.new_high_1cyc", int'(new_high), 0);
        check_eq("hs.score_held", int'(score), 8);
        step(0, 1, 0, 3'b000, 0);
        step(0, 0, 0, 3'b111, 0);
        step(0, 0, 0, 3'b111, 0);
        step(0, 0, 0, 3'b011, 0);
        step(0, 0, 0, 3'b000, 1);
        check_eq("tie.h_score", int'(h_score), 8);
        check_eq("tie.new_high", int'(new_high), 0);

        // robot_hit beats expiry and pause
        step(0, 1, 0, 3'b000, 0);
        repeat (59) step(1, 0, 0, 3'b000, 0);
        step(1, 0, 1, 3'b000, 1);
        check_eq("prio.state", int'(game_state), OVER);

        // Score saturation
        step(0, 1, 0, 3'b000, 0);
        repeat (3332) step(0, 0, 0, 3'b111, 0);
        step(0, 0, 0, 3'b011, 0);
        check_eq("sat.9998", int'(score), 9998);
        step(0, 0, 0, 3'b111, 0);
        check_eq("sat.9999", int'(score), MAXS);
        step(0, 0, 0, 3'b111, 0);
        check_eq("sat.hold", int'(score), MAXS);

        // Asynchronous reset in the middle of a round
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized play against the model
        p_lvl = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(39) == 0) p_lvl = ~p_lvl;
            step($urandom_range(3) == 0, $urandom_range(29) == 0, p_lvl,
                 3'($urandom_range(7) & $urandom_range(7) & $urandom_range(7)),
                 $urandom_range(249) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Central game sequencer for the dragon/robot shooter. It runs the round state machine and the round countdown timer, and it accumulates score from dragon-kill events. On robot death it commits the high score, and it issues the run-enable and respawn controls that gate the Dragon_move, Robot_move and Missile_move blocks. Its score, h_score and rounds outputs feed the INT2BCD/ssd display path.

Parameters:
SCORE_W, 14, width of the score, h_score and rounds counters.
MAX_SCORE, 9999, saturation value for score and rounds (the 4-digit display limit).
ROUND_TICKS, 60, tick count per round; loaded into time_left.
RESPAWN_TICKS, 8, tick count spent in RESPAWN between rounds.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
tick  input  1  one-cycle game-time enable strobe (derived from clk_22 or 1 Hz).
start  input  1  one-cycle start/restart pulse (debounced pushbutton).
pause  input  1  level pause switch.
hit  input  3  dragon-killed pulses, one bit per dragon (Event[3:1]).
robot_hit  input  1  robot-killed pulse (Event[0]).
game_state  output  3  0 IDLE, 1 PLAY, 2 PAUSED, 3 RESPAWN, 4 OVER.
run_en  output  1  movement enable to the sprite blocks; high only in PLAY.
respawn  output  3  one-cycle respawn strobe per dragon.
score  output  SCORE_W  current score.
h_score  output  SCORE_W  high score.
rounds  output  SCORE_W  current round number.
time_left  output  8  remaining ticks in the round.
new_high  output  1  one-cycle strobe when h_score is updated.

Behaviour:
- Reset (async, rst low): state IDLE, score 0, h_score 0, rounds 0, time_left 0, run_en 0, respawn 0, new_high 0.
- All outputs are registered. Every transition happens on a clk edge; the tick-gated actions below act only on cycles where tick=1.
- IDLE:
  - On start -> PLAY; rounds<=1, score<=0, time_left<=ROUND_TICKS, respawn<=3'b111 (one cycle).
- PLAY:
  - run_en=1.
  - Each cycle, score <= min(score + popcount(hit), MAX_SCORE). A 3'b111 hit adds 3.
  - On tick, time_left decrements.
  - Priority within one cycle: robot_hit > expiry > pause.
  - robot_hit -> OVER. Hits in the same cycle are still added before the high-score compare.
  - Expiry: tick with time_left==1 -> RESPAWN. time_left<=RESPAWN_TICKS; rounds <= min(rounds+1, MAX_SCORE).
  - pause=1 -> PAUSED.
- PAUSED:
  - run_en=0. hit and tick are ignored; time_left is frozen.
  - pause=0 -> PLAY with time_left preserved.
  - robot_hit is ignored.
- RESPAWN:
  - run_en=0. time_left decrements on tick.
  - Tick with time_left==1 -> PLAY; time_left<=ROUND_TICKS; respawn<=3'b111 for one cycle.
  - pause is honoured only after returning to PLAY.
- OVER:
  - run_en=0.
  - On entry, if final score > h_score: h_score<=final score and new_high pulses for 1 cycle. Ties do not update.
  - score is held for display.
  - start -> PLAY with score<=0, rounds<=1, time_left<=ROUND_TICKS, respawn<=3'b111. h_score is kept.
- start is ignored in PLAY, PAUSED and RESPAWN.
- respawn and new_high are never high for more than one cycle.
- Reset mid-round clears everything, including h_score.
- game_state encodings 5..7 are unreachable; if entered, recover to IDLE on the next cycle.

Test Plan:
- Reset then start pulse -> game_state=1, rounds=1, time_left=60, respawn=3'b111 for exactly 1 cycle, run_en=1.
- In PLAY, hit=3'b101 for 1 cycle, then 3'b111 for 1 cycle -> score=5. Preload score 9998, hit=3'b111 -> score=9999 (saturated).
- Let 60 ticks elapse -> on the 60th tick: state RESPAWN, rounds=2, run_en=0. After 8 more ticks: PLAY, time_left=60, respawn pulse.
- pause=1 at time_left=30; apply 10 ticks plus hit pulses -> state PAUSED, time_left=30, score unchanged. pause=0 -> PLAY, countdown resumes from 30.
- Score 7 with h_score 0, robot_hit together with hit=3'b001 -> OVER, h_score=8, new_high 1 cycle. Restart, reach score 8, robot_hit -> h_score stays 8, no new_high.
- Same cycle: robot_hit, tick at time_left=1 and pause=1 -> state OVER (priority check). Assert rst low mid-PLAY -> all outputs 0 immediately, asynchronously.
